run_length_tx: RTL
==================

// Module: run_length_tx
// PURPOSE
//   Serial run-length transmitter, the sending end of the zero-detector link.
//   Takes a run length N over a valid/ready handshake and drives x_out with N
//   consecutive 1s, then one terminating 0 (stop bit), then GAP idle 0s.
//   Its x_out drives the x_in of a zero detector. stop_strb marks the cycle
//   where a downstream detector raises y_out.
// PARAMETERS
//   LEN_W  4  width of run-length field; N ranges 0..2**LEN_W-1
//   GAP    1  idle-0 cycles after the stop bit before len_ready re-asserts (0 allowed)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-low
//   len_in     in   LEN_W  run length N, sampled on handshake
//   len_valid  in   1      len_in valid
//   len_ready  out  1      transmitter idle, can accept
//   x_out      out  1      serial line to detector x_in
//   busy       out  1      frame in progress (RUN, STOP or GAP)
//   stop_strb  out  1      high exactly during the stop-bit cycle when N>0
// BEHAVIOUR
//   - Reset (rst==0, async): state=IDLE, x_out=0, busy=0, stop_strb=0,
//     counters=0, len_ready=1 (combinational from IDLE).
//   - All outputs except len_ready are registered (Moore). len_ready = (state==IDLE).
//   - Accept on the rising edge where len_valid & len_ready. len_in is captured
//     into a down-counter.
//   - States:
//     IDLE : x_out=0. On accept, go to RUN if N>0, else go to STOP.
//     RUN  : x_out=1, counter decrements each cycle. When count reaches 1, go to STOP.
//            Exactly N cycles of 1.
//     STOP : x_out=0 for 1 cycle. stop_strb=1 iff the frame had N>0.
//            Go to GAP if GAP>0, else go to IDLE.
//     GAP  : x_out=0 for GAP cycles, then go to IDLE.
//   - Latency: first 1 appears in the cycle after the accept edge.
//     Frame length = N+1+GAP cycles. Next accept is possible the cycle after the frame ends.
//   - N=0: a lone stop bit, stop_strb=0. A downstream detector must not fire.
//   - N=2**LEN_W-1: full run, no counter wrap.
//   - len_valid while busy: ignored, no capture. Holding len_in is the upstream's responsibility.
//   - len_valid held high in IDLE: back-to-back frames, separated only by
//     stop bit, GAP, and one IDLE cycle.
//   - Reset mid-frame: x_out drops to 0 immediately (async). No partial
//     frame resumes after release; the block returns to IDLE and waits for a new handshake.
//   - x/undriven len_in is never sampled outside the handshake.
// STRUCTURE
//   - Shared package zd_link_pkg: state encoding localparams
//     IDLE=2'b00, RUN=2'b01, STOP=2'b10, GAP=2'b11, shared with the detector bench.
//   - Sub-module rl_down_counter #(W): load/dec/zero flag. Instantiated twice:
//     once for the run count (W=LEN_W), once for the gap count (W=$clog2(GAP+1)).
//   - Top level: one sequential state register block plus one combinational
//     next-state block.
// TESTING
//   - Reset: rst=0 mid-RUN with N=5 -> x_out=0, busy=0, len_ready=1 the same
//     cycle. After release, no further 1s without a new handshake.
//   - N=3, GAP=1 -> x_out sequence 1,1,1,0,0. stop_strb=1 only on the 4th cycle.
//     len_ready high again on the 6th cycle.
//   - N=0 -> one 0 cycle, stop_strb=0 throughout. Loopback detector y_out stays 0.
//   - N=15 (LEN_W=4) -> exactly 15 ones, then the stop bit. No wrap; busy is high
//     for 17 cycles.
//   - len_valid held high with len_in=2, GAP=0 -> repeating pattern 1,1,0,0(IDLE)
//     with an accept every 4 cycles.
//   - Loopback into zero detector with random N in 0..15 ->
//     y_out==stop_strb on every cycle, for >=1000 frames.

Source files
------------

// File: rtl/zd_link_pkg.sv
// Shared definitions for the zero-detector link.
// The state encoding is reused by the detector bench, so keep these values stable.
package zd_link_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STOP = 2'b10;
  localparam logic [1:0] ST_GAP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_STOP = ST_STOP,
    S_GAP  = ST_GAP
  } tx_state_e;

endpackage

// File: rtl/rl_down_counter.sv
// Loadable down-counter with a zero flag. It saturates at zero, so it never wraps.
// Ports:
//   clk, rst     clock, async active-low reset (count clears to 0)
//   i_load       load i_load_val (takes priority over i_dec)
//   i_load_val   value to load
//   i_dec        decrement by one while non-zero
//   o_zero_c     combinational: count == 0
module rl_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/run_length_tx.sv
// Serial run-length transmitter: sends N ones, one stop 0, then GAP idle 0s.
// Ports:
//   clk, rst    clock, async active-low reset
//   len_in      run length N, captured on the handshake
//   len_valid   len_in valid
//   len_ready   idle, can accept (combinational from state)
//   x_out       serial line (registered)
//   busy        frame in progress (registered)
//   stop_strb   high during the stop bit of a frame with N>0 (registered)
module run_length_tx
  import zd_link_pkg::*;
#(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] len_in,
  input  logic             len_valid,
  output logic             len_ready,
  output logic             x_out,
  output logic             busy,
  output logic             stop_strb
);

  // A zero-width counter is illegal, so GAP=0 keeps a 1-bit counter that is never loaded.
  localparam int unsigned GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  tx_state_e r_state;
  tx_state_e w_next;
  logic      r_x;
  logic      r_busy;
  logic      r_strb;

  logic w_accept;
  logic w_run_load;
  logic w_run_dec;
  logic w_run_zero;
  logic w_gap_load;
  logic w_gap_dec;
  logic w_gap_zero;
  logic w_x_next;
  logic w_busy_next;
  logic w_strb_next;

  assign len_ready = (r_state == S_IDLE);
  assign w_accept  = len_valid & len_ready;

  // The counters hold "cycles left after this one", so they are loaded with N-1 and GAP-1.
  rl_down_counter #(.W(LEN_W)) u_run_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_run_load),
    .i_load_val (LEN_W'(len_in - LEN_W'(1))),
    .i_dec      (w_run_dec),
    .o_zero_c   (w_run_zero)
  );

  rl_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gap_load),
    .i_load_val (GAP_W'(GAP_LOAD)),
    .i_dec      (w_gap_dec),
    .o_zero_c   (w_gap_zero)
  );

  // Next state, counter controls and next values of the registered outputs
  always_comb begin
    w_next     = r_state;
    w_run_load = 1'b0;
    w_run_dec  = 1'b0;
    w_gap_load = 1'b0;
    w_gap_dec  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (len_in != '0) begin
            w_next     = S_RUN;
            w_run_load = 1'b1;
          end else begin
            w_next = S_STOP;
          end
        end
      end
      S_RUN: begin
        if (w_run_zero) begin
          w_next = S_STOP;
        end else begin
          w_run_dec = 1'b1;
        end
      end
      S_STOP: begin
        if (GAP > 0) begin
          w_next     = S_GAP;
          w_gap_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_GAP: begin
        if (w_gap_zero) begin
          w_next = S_IDLE;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase

    w_x_next    = (w_next == S_RUN);
    w_busy_next = (w_next != S_IDLE);
    // Only a RUN->STOP transition marks a real stop bit; IDLE->STOP is the N=0 case.
    w_strb_next = (r_state == S_RUN) && (w_next == S_STOP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_strb  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_x     <= w_x_next;
      r_busy  <= w_busy_next;
      r_strb  <= w_strb_next;
    end
  end

  assign x_out     = r_x;
  assign busy      = r_busy;
  assign stop_strb = r_strb;

endmodule
